freqcode_ramp_tx: RTL and testbench

- Generates the W-bit thermometer frequency word q consumed by the frequency rebound controller. Ones fill from the LSB; all-ones is maximum code.
- Takes a target ones-count through a valid/ready handshake and ramps q toward it one bit per DWELL cycles, so the receiver never sees a multi-bit jump.
- After the last step it holds q for a settle window, pulses done, and returns to idle.
- Sits between the loop/calibration sequencer and the rebound controller's q input.

---
 rtl/freqcode_ramp_tx_pkg.sv | 21 ++
 rtl/freqcode_ramp_tx_therm_encode.sv | 14 +
 rtl/freqcode_ramp_tx.sv | 130 +++++++++++++
 tb/tb_freqcode_ramp_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/freqcode_ramp_tx_pkg.sv
// Shared types and defaults for the thermometer frequency-code ramp generator
// and the rebound controller bench.
package freqcode_pkg;

    typedef enum logic [1:0] {IDLE, STEP, SETTLE} state_t;

    localparam int DEF_DWELL      = 4;
    localparam int DEF_SETTLE_CYC = 32;

    function automatic int cw_of(input int w);
        return $clog2(w + 1);
    endfunction

    // Width able to hold max(a,b)-1, never narrower than one bit.
    function automatic int ctr_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/freqcode_ramp_tx_therm_encode.sv
// Count to LSB-filled thermometer code: q[i] = (i < count).
module therm_encode #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [CW-1:0] i_count,
    output logic [W-1:0]  o_q
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_q[i] = (i_count > CW'(i));
    end

endmodule

// File: rtl/freqcode_ramp_tx.sv
// Ramps the thermometer frequency word one bit per DWELL cycles toward a
// requested ones-count, holds for a settle window, then pulses done.
module freqcode_ramp_tx
    import freqcode_pkg::*;
#(
    parameter int  W          = 8,
    parameter int  DWELL      = DEF_DWELL,
    parameter int  SETTLE_CYC = DEF_SETTLE_CYC,
    localparam int CW         = cw_of(W)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          tgt_valid,
    output logic          tgt_ready,
    input  logic [CW-1:0] tgt_count,
    input  logic          abort,
    output logic [W-1:0]  q,
    output logic [CW-1:0] cur_count,
    output logic          busy,
    output logic          done
);

    localparam int CTW = ctr_w(DWELL, SETTLE_CYC);

    state_t         r_state;
    logic [CTW-1:0] r_dwell;
    logic [CTW-1:0] r_settle;
    logic [CW-1:0]  r_tgt;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_q;
    logic           r_ready;
    logic           r_busy;
    logic           r_done;

    logic [CW-1:0]  w_tgt_sat;
    logic           w_step;
    logic [CW-1:0]  w_cnt_nxt;
    logic [W-1:0]   w_q_nxt;

    assign w_tgt_sat = (tgt_count > CW'(W)) ? CW'(W) : tgt_count;

    // Abort suppresses a step that falls on the same edge.
    always_comb begin
        w_step    = (r_state == STEP) && !abort && (r_dwell == '0);
        w_cnt_nxt = r_cnt;
        if (w_step)
            w_cnt_nxt = (r_tgt > r_cnt) ? r_cnt + CW'(1) : r_cnt - CW'(1);
    end

    therm_encode #(.W(W), .CW(CW)) u_therm (
        .i_count (w_cnt_nxt),
        .o_q     (w_q_nxt)
    );

    always_ff @(posedge clk) begin
        if (rstb) begin
            r_state  <= IDLE;
            r_dwell  <= '0;
            r_settle <= '0;
            r_tgt    <= CW'(W);
            r_cnt    <= CW'(W);
            r_q      <= '1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= w_cnt_nxt;
            r_q    <= w_q_nxt;
            case (r_state)
                IDLE: begin
                    if (tgt_valid) begin
                        r_tgt   <= w_tgt_sat;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_tgt_sat == r_cnt) begin
                            r_state  <= SETTLE;
                            r_settle <= CTW'(SETTLE_CYC - 1);
                        end else begin
                            r_state <= STEP;
                            r_dwell <= CTW'(DWELL - 1);
                        end
                    end
                end
                STEP: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_dwell == '0) begin
                        if (w_cnt_nxt == r_tgt) begin
                            r_state  <= SETTLE;
                            r_settle <= CTW'(SETTLE_CYC - 1);
                        end else begin
                            r_dwell <= CTW'(DWELL - 1);
                        end
                    end else begin
                        r_dwell <= r_dwell - CTW'(1);
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_settle == '0) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_settle <= r_settle - CTW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q         = r_q;
    assign cur_count = r_cnt;
    assign tgt_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_freqcode_ramp_tx.sv
// Directed bench for freqcode_ramp_tx at W=8, DWELL=4, SETTLE_CYC=32.
module tb_freqcode_ramp_tx;

    logic       clk = 1'b0;
    logic       rstb = 1'b1;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] tgt_count = '0;
    logic       abort = 1'b0;
    logic [7:0] q;
    logic [3:0] cur_count;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;
    int nd;

    freqcode_ramp_tx #(.W(8), .DWELL(4), .SETTLE_CYC(32)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_count (tgt_count),
        .abort     (abort),
        .q         (q),
        .cur_count (cur_count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a target across one edge (edge 0 of the ramp).
    task automatic acc(input logic [3:0] t, input logic hold);
        tgt_count = t;
        tgt_valid = 1'b1;
        adv(1);
        if (!hold) tgt_valid = 1'b0;
    endtask

    initial begin
        // reset
        rstb = 1'b1;
        adv(3);
        rstb = 1'b0;
        chk("rst_q", q, 8'hFF);
        chk("rst_cnt", cur_count, 8);
        chk("rst_ready", tgt_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // down ramp 8 -> 3
        acc(4'd3, 1'b0);
        chk("dn_busy0", busy, 1);
        chk("dn_ready0", tgt_ready, 0);
        adv(3);  chk("dn_q3", q, 8'hFF);
        adv(1);  chk("dn_q4", q, 8'h7F);
        adv(4);  chk("dn_q8", q, 8'h3F);
        adv(4);  chk("dn_q12", q, 8'h1F);
        adv(4);  chk("dn_q16", q, 8'h0F);
        adv(4);  chk("dn_q20", q, 8'h07);
        chk("dn_cnt20", cur_count, 3);
        adv(31); chk("dn_done51", done, 0);
        chk("dn_busy51", busy, 1);
        adv(1);  chk("dn_done52", done, 1);
        chk("dn_ready52", tgt_ready, 1);
        chk("dn_busy52", busy, 0);
        adv(1);  chk("dn_done53", done, 0);

        // up ramp 3 -> 8
        acc(4'd8, 1'b0);
        adv(4);  chk("up_q4", q, 8'h0F);
        adv(4);  chk("up_q8", q, 8'h1F);
        adv(4);  chk("up_q12", q, 8'h3F);
        adv(4);  chk("up_q16", q, 8'h7F);
        adv(4);  chk("up_q20", q, 8'hFF);
        adv(31); chk("up_done51", done, 0);
        adv(1);  chk("up_done52", done, 1);

        // equal target: settle only
        acc(4'd8, 1'b0);
        chk("eq_busy0", busy, 1);
        adv(31); chk("eq_done31", done, 0);
        chk("eq_q31", q, 8'hFF);
        adv(1);  chk("eq_done32", done, 1);

        // saturation: 12 behaves as 8
        acc(4'd12, 1'b0);
        adv(4);  chk("sat_cnt4", cur_count, 8);
        chk("sat_q4", q, 8'hFF);
        adv(28); chk("sat_done32", done, 1);

        // abort mid-ramp 8 -> 0, tgt_valid held and ignored
        acc(4'd0, 1'b1);
        tgt_count = 4'd5;
        adv(4);  chk("ab_q4", q, 8'h7F);
        chk("ab_ready4", tgt_ready, 0);
        adv(4);  chk("ab_q8", q, 8'h3F);
        chk("ab_cnt8", cur_count, 6);
        adv(2);
        abort = 1'b1;
        tgt_valid = 1'b0;
        adv(1);  chk("ab_busy11", busy, 0);
        chk("ab_ready11", tgt_ready, 1);
        chk("ab_q11", q, 8'h3F);
        abort = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin adv(1); nd += int'(done); end
        chk("ab_nodone", nd, 0);
        chk("ab_qhold", q, 8'h3F);

        // abort on the same edge as a scheduled step (6 -> 8)
        acc(4'd8, 1'b0);
        adv(4);  chk("col_q4", q, 8'h7F);
        adv(3);
        abort = 1'b1;
        adv(1);  chk("col_busy8", busy, 0);
        chk("col_q8", q, 8'h7F);
        abort = 1'b0;
        adv(1);  chk("col_q9", q, 8'h7F);
        chk("col_cnt9", cur_count, 7);

        // abort in IDLE coinciding with accept: accept proceeds (7 -> 5)
        abort = 1'b1;
        acc(4'd5, 1'b0);
        abort = 1'b0;
        chk("ia_busy0", busy, 1);
        adv(4);  chk("ia_q4", q, 8'h3F);
        adv(4);  chk("ia_q8", q, 8'h1F);
        adv(32); chk("ia_done40", done, 1);

        // reset mid-ramp toward 0
        acc(4'd0, 1'b0);
        adv(4);  chk("rm_q4", q, 8'h0F);
        adv(1);
        rstb = 1'b1;
        adv(1);  chk("rm_q6", q, 8'hFF);
        chk("rm_cnt6", cur_count, 8);
        chk("rm_busy6", busy, 0);
        chk("rm_ready6", tgt_ready, 1);
        rstb = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin adv(1); nd += int'(done); end
        chk("rm_nodone", nd, 0);

        // new target 5 after reset
        acc(4'd5, 1'b0);
        adv(4);  chk("nt_q4", q, 8'h7F);
        adv(4);  chk("nt_q8", q, 8'h3F);
        adv(4);  chk("nt_q12", q, 8'h1F);
        chk("nt_cnt12", cur_count, 5);
        adv(31); chk("nt_done43", done, 0);
        adv(1);  chk("nt_done44", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
